// File: rtl/spdif_pkg.sv
// S/PDIF transmitter constants: preambles, subframe field map and timing.
package spdif_pkg;

   localparam int HC_PER_SF = 64;
   localparam int FRAMES    = 192;

   localparam logic [7:0] PRE_Z = 8'b1110_1000;
   localparam logic [7:0] PRE_X = 8'b1110_0010;
   localparam logic [7:0] PRE_Y = 8'b1110_0100;

   localparam int AUD_LSB = 4;
   localparam int AUD_MSB = 27;
   localparam int V_BIT   = 28;
   localparam int U_BIT   = 29;
   localparam int C_BIT   = 30;
   localparam int P_BIT   = 31;

   typedef enum logic {
      SUB_L = 1'b0,
      SUB_R = 1'b1
   } sub_e;

   // Bits 3:0 stay zero; the preamble is generated separately.
   function automatic logic [31:0] sf_word(
      input logic [23:0] aud,
      input logic        v,
      input logic        u,
      input logic        c
   );
      logic [31:0] w;
      w = '0;
      w[AUD_MSB:AUD_LSB] = aud;
      w[V_BIT] = v;
      w[U_BIT] = u;
      w[C_BIT] = c;
      w[P_BIT] = ^w[C_BIT:AUD_LSB];
      return w;
   endfunction

endpackage

// File: rtl/spdif_sample_fifo.sv
// Synchronous show-ahead FIFO holding stereo sample pairs.
module spdif_sample_fifo
   import spdif_pkg::*;
#(
   parameter int W     = 48,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] rd_data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wp_q;
   logic [AW:0]  rp_q;

   assign empty_o   = (wp_q == rp_q);
   assign full_o    = (wp_q[AW] != rp_q[AW]) &&
                      (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign rd_data_o = mem_q[rp_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (wr_en_i) begin
            mem_q[wp_q[AW-1:0]] <= wr_data_i;
            wp_q <= wp_q + 1'b1;
         end
         if (rd_en_i) begin
            rp_q <= rp_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/spdif_tx_param.sv
// S/PDIF transmitter: sample FIFO, frame/half-cell counters, C/U latch,
// parity and biphase-mark line encoder with a registered output.
module spdif_tx_param
   import spdif_pkg::*;
#(
   parameter int SAMPLE_W   = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                bit_out_en_i,
   input  logic [SAMPLE_W-1:0] sample_l_i,
   input  logic [SAMPLE_W-1:0] sample_r_i,
   input  logic                sample_valid_i,
   output logic                sample_ready_o,
   input  logic                valid_flag_i,
   input  logic [191:0]        cs_i,
   input  logic [191:0]        user_i,
   output logic                spdif_o,
   output logic                block_start_o,
   output logic                underrun_o
);

   logic [5:0]          hc_q, hc_d;
   sub_e                sub_q, sub_d;
   logic [7:0]          frame_q, frame_d;
   logic                load_q, load_d;
   logic [31:0]         word_q, word_d;
   logic                pinv_q, pinv_d;
   logic [SAMPLE_W-1:0] r_q, r_d;
   logic                urun_q, urun_d;
   logic [191:0]        cs_q, cs_d;
   logic [191:0]        us_q, us_d;
   logic                spdif_q, spdif_d;
   logic                bs_q, bs_d;
   logic                ur_q, ur_d;

   logic [2*SAMPLE_W-1:0] fifo_rd;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;
   logic                  push;
   logic [7:0]            pre;
   logic [191:0]          cs_use;
   logic [191:0]          us_use;
   logic [SAMPLE_W-1:0]   smp;
   logic                  vbit;

   assign pop  = bit_out_en_i & load_q & (sub_q == SUB_L) & ~fifo_empty;
   // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
   assign push = sample_valid_i & (~fifo_full | pop);

   spdif_sample_fifo #(
      .W     (2*SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (push),
      .wr_data_i ({sample_l_i, sample_r_i}),
      .rd_en_i   (pop),
      .rd_data_o (fifo_rd),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign pre = (sub_q == SUB_R) ? PRE_Y :
                (frame_q == 8'd0) ? PRE_Z : PRE_X;

   assign cs_use = (frame_q == 8'd0 && sub_q == SUB_L) ? cs_i : cs_q;
   assign us_use = (frame_q == 8'd0 && sub_q == SUB_L) ? user_i : us_q;

   always_comb begin
      hc_d    = hc_q;
      sub_d   = sub_q;
      frame_d = frame_q;
      load_d  = load_q;
      word_d  = word_q;
      pinv_d  = pinv_q;
      r_d     = r_q;
      urun_d  = urun_q;
      cs_d    = cs_q;
      us_d    = us_q;
      spdif_d = spdif_q;
      bs_d    = 1'b0;
      ur_d    = 1'b0;
      smp     = '0;
      vbit    = 1'b0;
      if (bit_out_en_i) begin
         hc_d   = hc_q + 6'd1;
         load_d = (hc_q == 6'(HC_PER_SF - 1));
         if (load_d) begin
            sub_d = (sub_q == SUB_L) ? SUB_R : SUB_L;
            if (sub_q == SUB_R) begin
               frame_d = (frame_q == 8'(FRAMES - 1)) ? 8'd0 : frame_q + 8'd1;
            end
         end
         if (load_q) begin
            pinv_d  = spdif_q;
            spdif_d = pre[7] ^ spdif_q;
            if (sub_q == SUB_L) begin
               smp    = fifo_empty ? '0 : fifo_rd[2*SAMPLE_W-1:SAMPLE_W];
               r_d    = fifo_empty ? '0 : fifo_rd[SAMPLE_W-1:0];
               urun_d = fifo_empty;
               vbit   = valid_flag_i | fifo_empty;
               ur_d   = fifo_empty;
               bs_d   = (frame_q == 8'd0);
               if (frame_q == 8'd0) begin
                  cs_d = cs_i;
                  us_d = user_i;
               end
            end else begin
               smp  = r_q;
               vbit = valid_flag_i | urun_q;
            end
            word_d = sf_word(24'(smp) << (24 - SAMPLE_W), vbit,
                             us_use[frame_q], cs_use[frame_q]);
         end else if (hc_q < 6'd8) begin
            spdif_d = pre[~hc_q[2:0]] ^ pinv_q;
         end else if (!hc_q[0]) begin
            spdif_d = ~spdif_q;
         end else begin
            spdif_d = spdif_q ^ word_q[hc_q[5:1]];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hc_q    <= '0;
         sub_q   <= SUB_L;
         frame_q <= '0;
         load_q  <= 1'b1;
         word_q  <= '0;
         pinv_q  <= 1'b0;
         r_q     <= '0;
         urun_q  <= 1'b0;
         cs_q    <= '0;
         us_q    <= '0;
         spdif_q <= 1'b0;
         bs_q    <= 1'b0;
         ur_q    <= 1'b0;
      end else begin
         hc_q    <= hc_d;
         sub_q   <= sub_d;
         frame_q <= frame_d;
         load_q  <= load_d;
         word_q  <= word_d;
         pinv_q  <= pinv_d;
         r_q     <= r_d;
         urun_q  <= urun_d;
         cs_q    <= cs_d;
         us_q    <= us_d;
         spdif_q <= spdif_d;
         bs_q    <= bs_d;
         ur_q    <= ur_d;
      end
   end

   assign spdif_o        = spdif_q;
   assign block_start_o  = bs_q;
   assign underrun_o     = ur_q;
   assign sample_ready_o = ~fifo_full;

endmodule

// File: tb/tb_spdif_tx_param.sv
// Directed bench: captures the line half-cell by half-cell and decodes it.
module tb_spdif_tx_param;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic [23:0]  sl = '0, sr = '0;
   logic         v = 1'b0;
   logic         ready;
   logic [15:0]  sl16 = '0, sr16 = '0;
   logic         v16 = 1'b0;
   logic         ready16;
   logic         vflag = 1'b0;
   logic [191:0] cs = '0, user = '0;
   logic         spdif, bs, ur;
   logic         spdif16, bs16, ur16;

   int checks = 0;
   int errors = 0;

   logic [63:0] hA, hB;
   logic        lastA, lastB;
   bit          bsA, urA;
   logic [7:0]  preA, preB;
   logic [31:0] wA, wB;
   bit          okA, okB;

   always #5 clk = ~clk;

   spdif_tx_param #(.SAMPLE_W(24), .FIFO_DEPTH(4)) dut (
      .clk_i(clk), .rst_i(rst), .bit_out_en_i(en),
      .sample_l_i(sl), .sample_r_i(sr),
      .sample_valid_i(v), .sample_ready_o(ready),
      .valid_flag_i(vflag), .cs_i(cs), .user_i(user),
      .spdif_o(spdif), .block_start_o(bs), .underrun_o(ur)
   );

   spdif_tx_param #(.SAMPLE_W(16), .FIFO_DEPTH(4)) dut16 (
      .clk_i(clk), .rst_i(rst), .bit_out_en_i(en),
      .sample_l_i(sl16), .sample_r_i(sr16),
      .sample_valid_i(v16), .sample_ready_o(ready16),
      .valid_flag_i(vflag), .cs_i(cs), .user_i(user),
      .spdif_o(spdif16), .block_start_o(bs16), .underrun_o(ur16)
   );

   function automatic void decode(input logic [63:0] h, input logic prev,
                                  output logic [7:0] pre,
                                  output logic [31:0] w, output bit ok);
      logic lv;
      ok = !$isunknown(h);
      w = '0;
      for (int i = 0; i < 8; i++) pre[7-i] = h[i] ^ prev;
      lv = h[7];
      for (int b = 4; b < 32; b++) begin
         if (h[2*b] === lv) ok = 0;
         w[b] = h[2*b] ^ h[2*b+1];
         lv = h[2*b+1];
      end
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; v = 1'b0; v16 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      lastA = 1'b0; lastB = 1'b0;
   endtask

   task automatic run_hc(input int n);
      bsA = 0; urA = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk); en = 1'b1;
         @(negedge clk); en = 1'b0;
         hA[i] = spdif; hB[i] = spdif16;
         if (bs) bsA = 1;
         if (ur) urA = 1;
      end
      lastA = hA[n-1]; lastB = hB[n-1];
   endtask

   task automatic run_sf();
      logic pA, pB;
      pA = lastA; pB = lastB;
      run_hc(64);
      decode(hA, pA, preA, wA, okA);
      decode(hB, pB, preB, wB, okB);
   endtask

   task automatic test_reset();
      do_reset();
      checks += 4;
      if (spdif !== 1'b0) begin errors++; $display("FAIL rst_spdif got %b want 0", spdif); end
      if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready); end
      if (bs !== 1'b0) begin errors++; $display("FAIL rst_bs got %b want 0", bs); end
      if (ur !== 1'b0) begin errors++; $display("FAIL rst_ur got %b want 0", ur); end
   endtask

   task automatic test_basic();
      cs = '0; user = '0; user[0] = 1'b1; vflag = 1'b0;
      do_reset();
      @(negedge clk); sl = 24'h123456; sr = 24'hABCDEF; v = 1'b1;
      @(negedge clk); v = 1'b0;
      run_sf();
      checks += 9;
      if (preA !== 8'hE8) begin errors++; $display("FAIL basic_preZ got %h want e8", preA); end
      if (!okA) begin errors++; $display("FAIL basic_bmcL got 0 want 1"); end
      if (wA[27:4] !== 24'h123456) begin errors++; $display("FAIL basic_audL got %h want 123456", wA[27:4]); end
      if (wA[28] !== 1'b0) begin errors++; $display("FAIL basic_vL got %b want 0", wA[28]); end
      if (wA[29] !== 1'b1) begin errors++; $display("FAIL basic_uL got %b want 1", wA[29]); end
      if (wA[30] !== 1'b0) begin errors++; $display("FAIL basic_cL got %b want 0", wA[30]); end
      if (^wA[31:4] !== 1'b0) begin errors++; $display("FAIL basic_parL got odd want even"); end
      if (!bsA) begin errors++; $display("FAIL basic_bs got 0 want 1"); end
      if (urA) begin errors++; $display("FAIL basic_ur got 1 want 0"); end
      run_sf();
      checks += 6;
      if (preA !== 8'hE4) begin errors++; $display("FAIL basic_preY got %h want e4", preA); end
      if (!okA) begin errors++; $display("FAIL basic_bmcR got 0 want 1"); end
      if (wA[27:4] !== 24'hABCDEF) begin errors++; $display("FAIL basic_audR got %h want abcdef", wA[27:4]); end
      if (wA[28] !== 1'b0) begin errors++; $display("FAIL basic_vR got %b want 0", wA[28]); end
      if (wA[29] !== 1'b1) begin errors++; $display("FAIL basic_uR got %b want 1", wA[29]); end
      if (^wA[31:4] !== 1'b0) begin errors++; $display("FAIL basic_parR got odd want even"); end
   endtask

   task automatic test_w16();
      user = '0;
      do_reset();
      @(negedge clk); sl16 = 16'h8001; sr16 = 16'h7FFF; v16 = 1'b1;
      @(negedge clk); v16 = 1'b0;
      run_sf();
      checks += 4;
      if (preB !== 8'hE8) begin errors++; $display("FAIL w16_pre got %h want e8", preB); end
      if (!okB) begin errors++; $display("FAIL w16_bmc got 0 want 1"); end
      if (wB[27:4] !== 24'h800100) begin errors++; $display("FAIL w16_audL got %h want 800100", wB[27:4]); end
      if (^wB[31:4] !== 1'b0) begin errors++; $display("FAIL w16_par got odd want even"); end
      run_sf();
      checks += 2;
      if (wB[27:4] !== 24'h7FFF00) begin errors++; $display("FAIL w16_audR got %h want 7fff00", wB[27:4]); end
      if (wB[28] !== 1'b0) begin errors++; $display("FAIL w16_vR got %b want 0", wB[28]); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] eL, eR;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         sl = 24'(32'h0A0001 + k * 32'h010101);
         sr = 24'(32'h050002 + k * 32'h020202);
         v = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ready); end
      sl = 24'(32'h0A0001 + 4 * 32'h010101);
      sr = 24'(32'h050002 + 4 * 32'h020202);
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL full_hold got %b want 0", ready); end
      for (int f = 0; f < 5; f++) begin
         eL = 24'(32'h0A0001 + f * 32'h010101);
         eR = 24'(32'h050002 + f * 32'h020202);
         run_sf();
         v = 1'b0;
         checks += 4;
         if (preA !== ((f == 0) ? 8'hE8 : 8'hE2)) begin errors++; $display("FAIL full_pre f%0d got %h", f, preA); end
         if (wA[27:4] !== eL) begin errors++; $display("FAIL full_audL f%0d got %h want %h", f, wA[27:4], eL); end
         if (urA) begin errors++; $display("FAIL full_ur f%0d got 1 want 0", f); end
         if (ready !== (f != 0)) begin errors++; $display("FAIL full_rdy f%0d got %b want %b", f, ready, f != 0); end
         run_sf();
         checks++;
         if (wA[27:4] !== eR) begin errors++; $display("FAIL full_audR f%0d got %h want %h", f, wA[27:4], eR); end
      end
      run_sf();
      checks += 3;
      if (!urA) begin errors++; $display("FAIL full_end_ur got 0 want 1"); end
      if (wA[27:4] !== 24'h0) begin errors++; $display("FAIL full_end_aud got %h want 0", wA[27:4]); end
      if (wA[28] !== 1'b1) begin errors++; $display("FAIL full_end_v got %b want 1", wA[28]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); sl = 24'h3C3C3C; sr = 24'hC3C3C3; v = 1'b1;
      end
      @(negedge clk); v = 1'b0;
      run_hc(30);
      @(negedge clk); rst = 1'b1; en = 1'b1;
      @(negedge clk);
      checks += 2;
      if (spdif !== 1'b0) begin errors++; $display("FAIL mid_spdif got %b want 0", spdif); end
      if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", ready); end
      rst = 1'b0; en = 1'b0;
      lastA = 1'b0; lastB = 1'b0;
      run_sf();
      checks += 5;
      if (preA !== 8'hE8) begin errors++; $display("FAIL mid_pre got %h want e8", preA); end
      if (!okA) begin errors++; $display("FAIL mid_bmc got 0 want 1"); end
      if (!bsA) begin errors++; $display("FAIL mid_bs got 0 want 1"); end
      if (!urA) begin errors++; $display("FAIL mid_ur got 0 want 1"); end
      if (wA[28] !== 1'b1) begin errors++; $display("FAIL mid_v got %b want 1", wA[28]); end
   endtask

   task automatic test_cs_underrun();
      logic [7:0] ep;
      cs = '0; cs[2] = 1'b1; user = '0; vflag = 1'b0;
      do_reset();
      for (int f = 0; f <= 192; f++) begin
         ep = (f % 192 == 0) ? 8'hE8 : 8'hE2;
         run_sf();
         if (f == 0) cs = '0;
         checks += 8;
         if (preA !== ep) begin errors++; $display("FAIL cs_preL f%0d got %h want %h", f, preA, ep); end
         if (!okA) begin errors++; $display("FAIL cs_bmcL f%0d got 0 want 1", f); end
         if (wA[27:4] !== 24'h0) begin errors++; $display("FAIL cs_audL f%0d got %h want 0", f, wA[27:4]); end
         if (wA[28] !== 1'b1) begin errors++; $display("FAIL cs_vL f%0d got %b want 1", f, wA[28]); end
         if (wA[30] !== (f == 2)) begin errors++; $display("FAIL cs_cL f%0d got %b want %b", f, wA[30], f == 2); end
         if (^wA[31:4] !== 1'b0) begin errors++; $display("FAIL cs_parL f%0d got odd want even", f); end
         if (!urA) begin errors++; $display("FAIL cs_ur f%0d got 0 want 1", f); end
         if (bsA !== (f % 192 == 0)) begin errors++; $display("FAIL cs_bs f%0d got %b want %b", f, bsA, f % 192 == 0); end
         run_sf();
         checks += 5;
         if (preA !== 8'hE4) begin errors++; $display("FAIL cs_preR f%0d got %h want e4", f, preA); end
         if (!okA) begin errors++; $display("FAIL cs_bmcR f%0d got 0 want 1", f); end
         if (wA[28] !== 1'b1) begin errors++; $display("FAIL cs_vR f%0d got %b want 1", f, wA[28]); end
         if (wA[30] !== (f == 2)) begin errors++; $display("FAIL cs_cR f%0d got %b want %b", f, wA[30], f == 2); end
         if (bsA) begin errors++; $display("FAIL cs_bsR f%0d got 1 want 0", f); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_w16();
      test_back_to_back();
      test_reset_mid();
      test_cs_underrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spdif_tx_param.md
SPDIF_TX_PARAM -- requirements
Module: spdif_tx_param

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 24, giving audio sample width per channel (legal 16..24).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving stereo pairs buffered (power of two, 2..16).
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk_i  in  1  system clock; rst_i  in  1  synchronous active-high reset.
REQ-004 bit_out_en_i  in  1  single-cycle strobe at 2x biphase bit rate (128 strobes per frame).
REQ-005 sample_l_i, sample_r_i  in  SAMPLE_W each  signed stereo pair.
REQ-006 sample_valid_i  in  1 / sample_ready_o  out  1  push handshake; transfer when both high on a clk_i edge.
REQ-007 valid_flag_i  in  1  V bit for transmitted samples (0 = valid audio).
REQ-008 cs_i  in  192  channel-status block, same for both channels, bit 0 first.
REQ-009 user_i  in  192  user-data block, same for both channels.
REQ-010 spdif_o  out  1  registered BMC line output.
REQ-011 block_start_o  out  1  one-cycle pulse when frame 0 (Z preamble) is loaded.
REQ-012 underrun_o  out  1  one-cycle pulse when a pair is needed and the FIFO is empty.

Function
REQ-013 Timing SHALL be 64 half-cells per subframe, 2 subframes per frame, 192 frames per block; frame counter wraps 191->0.
REQ-014 Subframe fields: bits 0-3 preamble, 4-27 audio MSB-aligned (sample in [27:28-SAMPLE_W], unused LSBs 0), 28 V, 29 U, 30 C, 31 P.
REQ-015 P SHALL make bits 4..31 even parity, computed over the actual transmitted bits.
REQ-016 Preambles (8 half-cells, first half-cell first) SHALL be Z=11101000 (frame 0, left), X=11100010 (other left), Y=11100100 (right), for a line level of 0 before the preamble; if that level is 1, the pattern is inverted.
REQ-017 Bits 4..31 SHALL be BMC: a transition at every cell start, plus a mid-cell transition for a 1.
REQ-018 spdif_o SHALL change only on the clk_i edge following a cycle with bit_out_en_i high.
REQ-019 cs_i and user_i SHALL be latched at each frame-0 load; C and U for frame n use latched bit n for both subframes.
REQ-020 A stereo pair SHALL be popped at the left-subframe load; the right sample is held for the following subframe.
REQ-021 On an empty FIFO at a pop point, the block SHALL send audio 0 with V=1 for both subframes, pulse underrun_o, and keep frame timing unchanged.
REQ-022 sample_ready_o SHALL equal FIFO not full.
REQ-023 A simultaneous push and pop on a full FIFO SHALL both be accepted, leaving occupancy unchanged.
REQ-024 A push while full without a pop SHALL not be accepted, because sample_ready_o is low.
REQ-025 Output latency from the load strobe to the first preamble half-cell on spdif_o SHALL be one clk_i cycle.

Reset
REQ-026 On rst_i, the block SHALL set spdif_o=0, sample_ready_o=1, block_start_o=0, underrun_o=0, and the FIFO to empty.
REQ-027 On rst_i, the frame counter SHALL be 0, the half-cell counter 0, and the load flag set.
REQ-028 The first strobe after reset SHALL start a Z subframe, reported through block_start_o and underrun_o if the FIFO is empty.
REQ-029 Reset mid-subframe SHALL abort the subframe immediately; no partial parity or frame state is retained.

Structure
REQ-030 Package spdif_pkg SHALL hold the preamble constants, frame count 192, subframe field positions and half-cell count 64.
REQ-031 Sub-module spdif_sample_fifo SHALL be a synchronous FIFO (width 2*SAMPLE_W, depth FIFO_DEPTH) with full and empty flags.
REQ-032 The BMC encoder, counters, channel-status latch and parity logic SHALL reside in spdif_tx_param.

Verification
REQ-033 Reset, push pair L=0x123456, R=0xABCDEF, then run one frame -> the bench decodes a Z preamble, L=0x123456, R=0xABCDEF, V=0, and correct even parity in both subframes.
REQ-034 SAMPLE_W=16, push L=0x8001 -> the decoded audio field equals 0x800100.
REQ-035 cs_i bit 2=1, others 0, run 192 frames -> C=1 only in frame 2, in both subframes; block_start_o pulses every 384 subframes.
REQ-036 No pushes after reset -> underrun_o pulses every frame, audio=0, V=1, and the preamble/BMC stay legal.
REQ-037 Fill to FIFO_DEPTH then push and pop in the same cycle -> sample_ready_o stays low, no data is lost, and the order is preserved.
REQ-038 Assert rst_i at half-cell 30 of a subframe -> spdif_o=0 next cycle, and the next strobe starts a Z preamble.
